// File: rtl/iw_writeback_stage.sv
// Writeback stage: commits IM/IW results to a 32x32 register file with write-first
// read bypass, issues PC redirects and counts retired (non-bubble) instructions.
module iw_writeback_stage #(
    parameter int LINK_REG        = 31,
    parameter int JAL_LINK_OFFSET = 8,
    parameter int COUNT_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_in,
    input  logic [31:0]            pc_in,
    input  logic [31:0]            O_in,
    input  logic [31:0]            mem_data_in,
    input  logic                   res_data_sel_in,
    input  logic                   write_to_reg_in,
    input  logic                   dest_reg_sel_in,
    input  logic [4:0]             rt_in,
    input  logic [4:0]             rd_in,
    input  logic                   update_pc_in,
    input  logic                   is_jal_in,
    input  logic [4:0]             rs_addr,
    input  logic [4:0]             rt_addr,
    output logic [31:0]            rs_data,
    output logic [31:0]            rt_data,
    output logic                   wb_valid,
    output logic [4:0]             wb_addr,
    output logic [31:0]            wb_data,
    output logic                   pc_redirect_valid,
    output logic [31:0]            pc_redirect_target,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    logic [31:0] regs [32];
    logic        live;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] data;

    always_comb begin
        live = !stall_in;
        dest = rt_in;
        if (is_jal_in)
            dest = 5'(LINK_REG);
        else if (dest_reg_sel_in)
            dest = rd_in;
        data = O_in;
        if (is_jal_in)
            data = pc_in + 32'(JAL_LINK_OFFSET);
        else if (res_data_sel_in)
            data = mem_data_in;
        // Reset gates the write so neither the array nor the bypass sees it.
        we = live && (write_to_reg_in || is_jal_in) && (dest != 5'd0) && !rst;
    end

    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == 5'd0)
            rs_data = '0;
        else if (we && (rs_addr == dest))
            rs_data = data;
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == 5'd0)
            rt_data = '0;
        else if (we && (rt_addr == dest))
            rt_data = data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (we) begin
            regs[dest] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= we;
            if (we) begin
                wb_addr <= dest;
                wb_data <= data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_redirect_valid  <= 1'b0;
            pc_redirect_target <= '0;
        end else begin
            pc_redirect_valid <= live && update_pc_in;
            if (live && update_pc_in)
                pc_redirect_target <= O_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired_count <= '0;
        else if (live)
            retired_count <= retired_count + COUNT_WIDTH'(1);
    end

endmodule
